// File: rtl/qpsk_frame_sync.sv
// QPSK frame synchroniser: finds a 32-bit sync word under all four carrier-phase hypotheses,
// removes the detected rotation and packs payload dibits into bytes with a flywheel CHECK.
module qpsk_frame_sync #(
   parameter logic [31:0] SYNC_WORD     = 32'h1ACFFC1D,
   parameter int unsigned PAYLOAD_BYTES = 32,
   parameter int unsigned MAX_ERR       = 2,
   parameter int unsigned MISS_LIMIT    = 3
) (
   input  logic       clk_1M024,
   input  logic       rst_n_1M024,
   input  logic [1:0] in_dibit,
   input  logic       in_valid,
   output logic [7:0] data_tdata,
   output logic       data_tvalid,
   output logic       data_tuser,
   output logic       data_tlast,
   output logic       lock,
   output logic [1:0] phase_rot,
   output logic       sync_err
);

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CHECK   = 2'd2
   } state_t;

   // Apply the 90-degree rotation {i,q} -> {~q,i} n times.
   function automatic logic [1:0] rot_n(input logic [1:0] d, input logic [1:0] n);
      logic [1:0] r;
      r = d;
      for (int i = 0; i < 3; i++) begin
         if (i < int'(n)) begin
            r = {~r[0], r[1]};
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w, input logic [1:0] n);
      logic [31:0] r;
      r = 32'd0;
      for (int i = 0; i < 16; i++) begin
         r[2*i +: 2] = rot_n(w[2*i +: 2], n);
      end
      return r;
   endfunction

   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] c;
      c = 6'd0;
      for (int i = 0; i < 32; i++) begin
         c = c + {5'd0, v[i]};
      end
      return c;
   endfunction

   state_t      state_q, state_d;
   logic [31:0] sr_q, sr_d;
   logic [1:0]  phase_q, phase_d;
   logic [3:0]  miss_q, miss_d;
   logic [5:0]  part_q, part_d;
   logic [1:0]  dib_cnt_q, dib_cnt_d;
   logic [7:0]  byte_cnt_q, byte_cnt_d;
   logic [3:0]  chk_cnt_q, chk_cnt_d;
   logic [7:0]  tdata_q, tdata_d;
   logic        tvalid_q, tvalid_d;
   logic        tuser_q, tuser_d;
   logic        tlast_q, tlast_d;
   logic        lock_q, lock_d;
   logic        serr_q, serr_d;

   logic [31:0] sr_next_s;
   logic [3:0]  match_s;
   logic [1:0]  hit_k_s;
   logic [1:0]  derot_s;

   assign sr_next_s = {sr_q[29:0], in_dibit};
   assign derot_s   = rot_n(in_dibit, 2'd0 - phase_q);

   // Sync correlation against all four rotated references, lowest k wins.
   always_comb begin
      match_s = 4'd0;
      hit_k_s = 2'd0;
      for (int k = 0; k < 4; k++) begin
         match_s[k] = (popcount32(sr_next_s ^ rot_word(SYNC_WORD, 2'(k))) <= 6'(MAX_ERR));
      end
      if (match_s[0]) begin
         hit_k_s = 2'd0;
      end else if (match_s[1]) begin
         hit_k_s = 2'd1;
      end else if (match_s[2]) begin
         hit_k_s = 2'd2;
      end else begin
         hit_k_s = 2'd3;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      phase_d    = phase_q;
      miss_d     = miss_q;
      part_d     = part_q;
      dib_cnt_d  = dib_cnt_q;
      byte_cnt_d = byte_cnt_q;
      chk_cnt_d  = chk_cnt_q;
      tdata_d    = tdata_q;
      tvalid_d   = 1'b0;
      tuser_d    = 1'b0;
      tlast_d    = 1'b0;
      serr_d     = 1'b0;
      if (in_valid) begin
         sr_d = sr_next_s;
         case (state_q)
            ST_SEARCH: begin
               if (|match_s) begin
                  phase_d    = hit_k_s;
                  miss_d     = 4'd0;
                  part_d     = 6'd0;
                  dib_cnt_d  = 2'd0;
                  byte_cnt_d = 8'd0;
                  state_d    = ST_PAYLOAD;
               end else begin
                  state_d = ST_SEARCH;
               end
            end
            ST_PAYLOAD: begin
               part_d    = {part_q[3:0], derot_s};
               dib_cnt_d = dib_cnt_q + 2'd1;
               if (dib_cnt_q == 2'd3) begin
                  tvalid_d = 1'b1;
                  tdata_d  = {part_q, derot_s};
                  tuser_d  = (byte_cnt_q == 8'd0);
                  if (byte_cnt_q == 8'(PAYLOAD_BYTES - 1)) begin
                     tlast_d    = 1'b1;
                     byte_cnt_d = 8'd0;
                     chk_cnt_d  = 4'd0;
                     state_d    = ST_CHECK;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 8'd1;
                  end
               end else begin
                  tvalid_d = 1'b0;
               end
            end
            ST_CHECK: begin
               chk_cnt_d = chk_cnt_q + 4'd1;
               if (chk_cnt_q == 4'd15) begin
                  part_d     = 6'd0;
                  dib_cnt_d  = 2'd0;
                  byte_cnt_d = 8'd0;
                  if (match_s[phase_q]) begin
                     miss_d  = 4'd0;
                     state_d = ST_PAYLOAD;
                  end else begin
                     serr_d = 1'b1;
                     miss_d = miss_q + 4'd1;
                     // Out of flywheel budget: re-acquire, keeping SR so the next dibit can match.
                     if (({1'b0, miss_q} + 5'd1) >= 5'(MISS_LIMIT)) begin
                        state_d = ST_SEARCH;
                     end else begin
                        state_d = ST_PAYLOAD;
                     end
                  end
               end else begin
                  state_d = ST_CHECK;
               end
            end
            default: begin
               state_d = ST_SEARCH;
            end
         endcase
      end else begin
         sr_d = sr_q;
      end
      lock_d = (state_d != ST_SEARCH);
   end

   // State and output registers.
   always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
      if (!rst_n_1M024) begin
         state_q    <= ST_SEARCH;
         sr_q       <= 32'd0;
         phase_q    <= 2'd0;
         miss_q     <= 4'd0;
         part_q     <= 6'd0;
         dib_cnt_q  <= 2'd0;
         byte_cnt_q <= 8'd0;
         chk_cnt_q  <= 4'd0;
         tdata_q    <= 8'd0;
         tvalid_q   <= 1'b0;
         tuser_q    <= 1'b0;
         tlast_q    <= 1'b0;
         lock_q     <= 1'b0;
         serr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         phase_q    <= phase_d;
         miss_q     <= miss_d;
         part_q     <= part_d;
         dib_cnt_q  <= dib_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         chk_cnt_q  <= chk_cnt_d;
         tdata_q    <= tdata_d;
         tvalid_q   <= tvalid_d;
         tuser_q    <= tuser_d;
         tlast_q    <= tlast_d;
         lock_q     <= lock_d;
         serr_q     <= serr_d;
      end
   end

   assign data_tdata  = tdata_q;
   assign data_tvalid = tvalid_q;
   assign data_tuser  = tuser_q;
   assign data_tlast  = tlast_q;
   assign lock        = lock_q;
   assign phase_rot   = phase_q;
   assign sync_err    = serr_q;

endmodule

// File: tb/tb_qpsk_frame_sync.sv
// Directed bench for qpsk_frame_sync: table of stream scenarios plus hand sequences for
// latency, mid-frame reset and the single-byte-frame instance.
module tb_qpsk_frame_sync;

   localparam logic [31:0] SYNC = 32'h1ACFFC1D;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic [1:0] in_dibit = 2'b00;
   logic       in_valid = 1'b0;

   logic [7:0] tdata, tdata1;
   logic       tvalid, tuser, tlast, lock, serr;
   logic       tvalid1, tuser1, tlast1, lock1, serr1;
   logic [1:0] phase, phase1;

   always #5 clk = ~clk;

   qpsk_frame_sync dut (
      .clk_1M024(clk), .rst_n_1M024(rst_n), .in_dibit(in_dibit), .in_valid(in_valid),
      .data_tdata(tdata), .data_tvalid(tvalid), .data_tuser(tuser), .data_tlast(tlast),
      .lock(lock), .phase_rot(phase), .sync_err(serr)
   );

   qpsk_frame_sync #(.PAYLOAD_BYTES(1)) dut1 (
      .clk_1M024(clk), .rst_n_1M024(rst_n), .in_dibit(in_dibit), .in_valid(in_valid),
      .data_tdata(tdata1), .data_tvalid(tvalid1), .data_tuser(tuser1), .data_tlast(tlast1),
      .lock(lock1), .phase_rot(phase1), .sync_err(serr1)
   );

   int checks   = 0;
   int failures = 0;

   // Byte monitor: {tuser, tlast, tdata} per tvalid pulse.
   logic [9:0] mon_q[$];
   int serr_cnt = 0;
   int bad_side = 0;
   int last_cnt = 0;
   always @(negedge clk) begin
      if (tvalid) begin
         mon_q.push_back({tuser, tlast, tdata});
         if (tlast) last_cnt++;
      end
      if (!tvalid && (tuser || tlast)) bad_side++;
      if (serr) serr_cnt++;
   end

   typedef struct {
      int          rot;
      logic [31:0] err [4];
      int          nframes;
      int          last_bytes;
      int          duty;
      int          exp_bytes;
      int          exp_serr;
      logic        exp_lock;
      logic [1:0]  exp_phase;
   } vec_t;

   vec_t vecs[8];

   function automatic vec_t mk(int rot, logic [31:0] e0, logic [31:0] e1, logic [31:0] e2,
                               logic [31:0] e3, int nf, int lb, int duty, int eb, int es,
                               logic el, logic [1:0] ep);
      vec_t v;
      v.rot = rot; v.err[0] = e0; v.err[1] = e1; v.err[2] = e2; v.err[3] = e3;
      v.nframes = nf; v.last_bytes = lb; v.duty = duty;
      v.exp_bytes = eb; v.exp_serr = es; v.exp_lock = el; v.exp_phase = ep;
      return v;
   endfunction

   function automatic logic [1:0] tb_rot(input logic [1:0] d, input int k);
      logic [1:0] r;
      r = d;
      for (int i = 0; i < k; i++) r = {~r[0], r[1]};
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [1:0] d, input int duty);
      while (duty < 100 && int'($urandom_range(99)) >= duty) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_dibit = d;
      in_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int k, input logic [31:0] err, input int duty);
      for (int i = 15; i >= 0; i--) send(tb_rot(w[2*i +: 2], k) ^ err[2*i +: 2], duty);
   endtask

   task automatic send_byte(input logic [7:0] b, input int k, input int duty);
      for (int i = 3; i >= 0; i--) send(tb_rot(b[2*i +: 2], k), duty);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_dibit = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] all_out();
      return {16'd0, tdata, tvalid, tuser, tlast, lock, phase, serr};
   endfunction

   initial begin
      int base, sbase, bbase, lbase, got, nb;

      // rot, sync error masks per frame, frames, bytes in last frame, duty%, expectations
      vecs[0] = mk(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32, 100, 32, 0, 1'b1, 2'd0);
      vecs[1] = mk(1, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32, 100, 32, 0, 1'b1, 2'd1);
      vecs[2] = mk(3, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32, 100, 32, 0, 1'b1, 2'd3);
      vecs[3] = mk(0, 32'h0000_0101, 32'h0, 32'h0, 32'h0, 1, 32, 100, 32, 0, 1'b1, 2'd0);
      vecs[4] = mk(0, 32'h8000_0011, 32'h0, 32'h0, 32'h0, 1, 1, 100, 0, 0, 1'b0, 2'd0);
      vecs[5] = mk(0, 32'h0, 32'h8000_0011, 32'h0, 32'h0, 2, 32, 100, 64, 1, 1'b1, 2'd0);
      vecs[6] = mk(0, 32'h0, 32'h8000_0011, 32'h0400_2001, 32'h0010_0300, 4, 1, 100, 96, 3, 1'b0, 2'd0);
      vecs[7] = mk(0, 32'h0, 32'h0, 32'h0, 32'h0, 3, 32, 30, 96, 0, 1'b1, 2'd0);

      // Reset state, sync-to-lock timing and byte latency.
      do_reset();
      check("reset outputs", all_out(), 32'd0);
      for (int i = 15; i >= 1; i--) send(SYNC[2*i +: 2], 100);
      send(SYNC[1:0], 100);
      check("lock before match", {31'd0, lock}, 32'd0);
      @(posedge clk); #1;
      check("lock after match", {30'd0, lock, 1'b0}, {30'd0, 1'b1, 1'b0});
      send(2'b10, 100); send(2'b10, 100); send(2'b01, 100); send(2'b01, 100);
      check("tvalid before 4th edge", {31'd0, tvalid}, 32'd0);
      @(posedge clk); #1;
      check("first byte", {21'd0, tvalid, tuser, tlast, tdata}, {21'd0, 1'b1, 1'b1, 1'b0, 8'hA5});
      check("pb1 byte", {21'd0, tvalid1, tuser1, tlast1, tdata1}, {21'd0, 1'b1, 1'b1, 1'b1, 8'hA5});
      idle(1);
      @(posedge clk); #1;
      check("hold after byte", {21'd0, tvalid, tuser, tlast, tdata}, {21'd0, 1'b0, 1'b0, 1'b0, 8'hA5});

      // Scenario table.
      for (int vi = 0; vi < 8; vi++) begin
         do_reset();
         base  = mon_q.size();
         sbase = serr_cnt;
         bbase = bad_side;
         if (vecs[vi].rot != 0) begin
            for (int i = 0; i < 16; i++) send(tb_rot(2'b00, vecs[vi].rot), 100);
         end
         for (int f = 0; f < vecs[vi].nframes; f++) begin
            send_word(SYNC, vecs[vi].rot, vecs[vi].err[f], vecs[vi].duty);
            nb = (f == vecs[vi].nframes - 1) ? vecs[vi].last_bytes : 32;
            for (int b = 0; b < nb; b++) send_byte(8'(b), vecs[vi].rot, vecs[vi].duty);
         end
         idle(4);
         got = mon_q.size() - base;
         check($sformatf("v%0d byte count", vi), got, vecs[vi].exp_bytes);
         for (int i = 0; i < got && i < vecs[vi].exp_bytes; i++) begin
            check($sformatf("v%0d byte%0d", vi, i), {22'd0, mon_q[base + i]},
                  {22'd0, (i % 32 == 0), (i % 32 == 31), 8'(i % 32)});
         end
         check($sformatf("v%0d lock", vi), {31'd0, lock}, {31'd0, vecs[vi].exp_lock});
         check($sformatf("v%0d phase", vi), {30'd0, phase}, {30'd0, vecs[vi].exp_phase});
         check($sformatf("v%0d sync_err pulses", vi), serr_cnt - sbase, vecs[vi].exp_serr);
         check($sformatf("v%0d side bands idle", vi), bad_side - bbase, 32'd0);
      end

      // Reset in the middle of byte 10, then a clean frame.
      do_reset();
      base  = mon_q.size();
      lbase = last_cnt;
      send_word(SYNC, 0, 32'h0, 100);
      for (int b = 0; b < 10; b++) send_byte(8'(b), 0, 100);
      send(2'b00, 100); send(2'b00, 100);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("outputs in reset", all_out(), 32'd0);
      repeat (2) @(negedge clk);
      check("outputs held in reset", all_out(), 32'd0);
      rst_n = 1'b1;
      send_word(SYNC, 0, 32'h0, 100);
      for (int b = 0; b < 32; b++) send_byte(8'(b), 0, 100);
      idle(4);
      got = mon_q.size() - base;
      check("rst byte count", got, 32'd42);
      for (int i = 0; i < got && i < 42; i++) begin
         if (i < 10) begin
            check($sformatf("rst pre byte%0d", i), {22'd0, mon_q[base + i]},
                  {22'd0, (i == 0), 1'b0, 8'(i)});
         end else begin
            check($sformatf("rst post byte%0d", i - 10), {22'd0, mon_q[base + i]},
                  {22'd0, (i == 10), (i == 41), 8'(i - 10)});
         end
      end
      check("rst tlast count", last_cnt - lbase, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
